// File: rtl/cpu_pkg.sv
// Shared encodings and default timing constants for the unified-memory arbiter.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  localparam int LAT_DEF            = 2;
  localparam int MAX_DATA_BURST_DEF = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// CPU fetch/data ports and the shared memory port, bundled for the arbiter.
interface mem_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ack;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ack;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  // slave: the arbiter's view; master: the core plus memory around it
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_rdata, if_ack, d_rdata, d_ack, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_rdata, if_ack, d_rdata, d_ack, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/arb_prio.sv
// Winner selection: data first, fetch forced once after MAX_DATA_BURST data grants.
module arb_prio
  import cpu_pkg::*;
#(
  parameter int MAX_DATA_BURST = MAX_DATA_BURST_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic d_req,
  input  logic grant,
  output logic winner
);

  logic [3:0] starve;

  always_comb begin
    winner = OWN_D;
    if (if_req && (!d_req || starve == 4'(MAX_DATA_BURST)))
      winner = OWN_IF;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      starve <= '0;
    else if (grant) begin
      if (winner == OWN_IF)
        starve <= '0;
      else if (if_req)
        starve <= starve + 4'd1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one fixed-latency single-ported memory between CPU fetch and data ports.
//   state | meaning
//   IDLE  | waiting for a request; latches winner's address/we/wdata
//   ISSUE | mem_en strobe; stores finish here, loads arm the latency counter
//   WAIT  | counting down read latency; captures mem_rdata at count 1
//   RESP  | owner's ack pulse
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int AW             = 16,
  parameter int DW             = 16,
  parameter int LAT            = LAT_DEF,
  parameter int MAX_DATA_BURST = MAX_DATA_BURST_DEF
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus,
  output logic          busy,
  output logic          owner
);

  state_t        state, state_n;
  logic [2:0]    cnt, cnt_n;
  logic          en_q, en_n;
  logic          we_q, we_n;
  logic [AW-1:0] addr_q, addr_n;
  logic [DW-1:0] wdata_q, wdata_n;
  logic [DW-1:0] if_rd_q, if_rd_n;
  logic [DW-1:0] d_rd_q, d_rd_n;
  logic          if_ack_q, if_ack_n;
  logic          d_ack_q, d_ack_n;
  logic          owner_q, owner_n;
  logic          grant, winner;

  assign grant = (state == IDLE) && (bus.if_req || bus.d_req);

  arb_prio #(.MAX_DATA_BURST(MAX_DATA_BURST)) u_prio (
    .clk    (clk),
    .rst    (rst),
    .if_req (bus.if_req),
    .d_req  (bus.d_req),
    .grant  (grant),
    .winner (winner)
  );

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    en_n     = 1'b0;
    we_n     = we_q;
    addr_n   = addr_q;
    wdata_n  = wdata_q;
    if_rd_n  = if_rd_q;
    d_rd_n   = d_rd_q;
    if_ack_n = 1'b0;
    d_ack_n  = 1'b0;
    owner_n  = owner_q;
    case (state)
      IDLE: begin
        if (grant) begin
          owner_n = winner;
          en_n    = 1'b1;
          state_n = ISSUE;
          if (winner == OWN_D) begin
            we_n    = bus.d_we;
            addr_n  = bus.d_addr;
            wdata_n = bus.d_wdata;
          end else begin
            we_n    = 1'b0;
            addr_n  = bus.if_addr;
            wdata_n = '0;
          end
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_n  = RESP;
          if_ack_n = (owner_q == OWN_IF);
          d_ack_n  = (owner_q == OWN_D);
        end else begin
          cnt_n   = 3'(LAT);
          state_n = WAIT;
        end
      end
      WAIT: begin
        cnt_n = cnt - 3'd1;
        if (cnt == 3'd1) begin
          state_n = RESP;
          if (owner_q == OWN_IF) begin
            if_rd_n  = bus.mem_rdata;
            if_ack_n = 1'b1;
          end else begin
            d_rd_n  = bus.mem_rdata;
            d_ack_n = 1'b1;
          end
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      en_q     <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      if_rd_q  <= '0;
      d_rd_q   <= '0;
      if_ack_q <= 1'b0;
      d_ack_q  <= 1'b0;
      owner_q  <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      en_q     <= en_n;
      we_q     <= we_n;
      addr_q   <= addr_n;
      wdata_q  <= wdata_n;
      if_rd_q  <= if_rd_n;
      d_rd_q   <= d_rd_n;
      if_ack_q <= if_ack_n;
      d_ack_q  <= d_ack_n;
      owner_q  <= owner_n;
    end
  end

  assign bus.mem_en    = en_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.if_rdata  = if_rd_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.d_rdata   = d_rd_q;
  assign bus.d_ack     = d_ack_q;
  assign busy          = (state != IDLE);
  assign owner         = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: three arbiters (LAT=1,2,3) each with a small fixed-latency memory model.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic busy1, busy2, busy3, own1, own2, own3;
  int   n_cmp = 0;
  int   n_err = 0;

  mem_arbiter_if #(.AW(16), .DW(16)) b1 ();
  mem_arbiter_if #(.AW(16), .DW(16)) b2 ();
  mem_arbiter_if #(.AW(16), .DW(16)) b3 ();

  mem_arbiter #(.AW(16), .DW(16), .LAT(1), .MAX_DATA_BURST(4)) u_lat1 (
    .clk(clk), .rst(rst), .bus(b1), .busy(busy1), .owner(own1));
  mem_arbiter #(.AW(16), .DW(16), .LAT(2), .MAX_DATA_BURST(4)) u_lat2 (
    .clk(clk), .rst(rst), .bus(b2), .busy(busy2), .owner(own2));
  mem_arbiter #(.AW(16), .DW(16), .LAT(3), .MAX_DATA_BURST(4)) u_lat3 (
    .clk(clk), .rst(rst), .bus(b3), .busy(busy3), .owner(own3));

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    return (a == 16'h0002) ? 16'h1234 : (a ^ 16'hA5A5);
  endfunction

  // read data appears exactly LAT cycles after the mem_en cycle, junk otherwise
  logic [15:0] p1;
  logic [15:0] p2 [2];
  logic [15:0] p3 [3];
  always @(posedge clk) begin
    p1    <= (b1.mem_en && !b1.mem_we) ? mem_fn(b1.mem_addr) : 16'hDEAD;
    p2[0] <= (b2.mem_en && !b2.mem_we) ? mem_fn(b2.mem_addr) : 16'hDEAD;
    p2[1] <= p2[0];
    p3[0] <= (b3.mem_en && !b3.mem_we) ? mem_fn(b3.mem_addr) : 16'hDEAD;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign b1.mem_rdata = p1;
  assign b2.mem_rdata = p2[1];
  assign b3.mem_rdata = p3[2];

  task automatic test_reset();
    logic [69:0] outs;
    int seen;
    repeat (2) @(negedge clk);
    outs = {b2.mem_en, b2.mem_we, b2.mem_addr, b2.mem_wdata, b2.if_rdata,
            b2.d_rdata, b2.if_ack, b2.d_ack, busy2, own2};
    n_cmp++;
    if (outs !== '0) begin
      n_err++; $display("FAIL reset_init: got %h expected 0", outs);
    end
    rst = 1'b0;
    @(negedge clk);
    b2.d_req = 1'b1; b2.d_we = 1'b0; b2.d_addr = 16'h0100;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (busy2 !== 1'b1 || own2 !== 1'b1) begin
      n_err++; $display("FAIL reset_wait_busy: got busy=%b owner=%b expected 1 1", busy2, own2);
    end
    rst = 1'b1;
    b2.d_req = 1'b0;
    #1;
    outs = {b2.mem_en, b2.mem_we, b2.mem_addr, b2.mem_wdata, b2.if_rdata,
            b2.d_rdata, b2.if_ack, b2.d_ack, busy2, own2};
    n_cmp++;
    if (outs !== '0) begin
      n_err++; $display("FAIL reset_midwait: got %h expected 0", outs);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (b2.d_ack || b2.if_ack || busy2) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_err++; $display("FAIL reset_after: got %0d ack/busy cycles expected 0", seen);
    end
  endtask

  task automatic test_store();
    @(negedge clk);
    b2.d_req = 1'b1; b2.d_we = 1'b1; b2.d_addr = 16'h0040; b2.d_wdata = 16'hBEEF;
    @(negedge clk);
    n_cmp++;
    if ({b2.mem_en, b2.mem_we, b2.mem_addr, b2.mem_wdata, b2.d_ack} !== {1'b1, 1'b1, 16'h0040, 16'hBEEF, 1'b0}) begin
      n_err++;
      $display("FAIL store_issue: got en=%b we=%b addr=%h wdata=%h ack=%b expected 1 1 0040 beef 0",
               b2.mem_en, b2.mem_we, b2.mem_addr, b2.mem_wdata, b2.d_ack);
    end
    @(negedge clk);
    n_cmp++;
    if ({b2.d_ack, b2.if_ack, own2, b2.mem_en} !== 4'b1010) begin
      n_err++;
      $display("FAIL store_ack: got d_ack=%b if_ack=%b owner=%b mem_en=%b expected 1 0 1 0",
               b2.d_ack, b2.if_ack, own2, b2.mem_en);
    end
    b2.d_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({b2.d_ack, busy2} !== 2'b00) begin
      n_err++; $display("FAIL store_done: got d_ack=%b busy=%b expected 0 0", b2.d_ack, busy2);
    end
  endtask

  task automatic test_load();
    int ack_at, n_ack;
    logic [15:0] rd;
    ack_at = -1; n_ack = 0; rd = '0;
    @(negedge clk);
    b3.if_req = 1'b1; b3.if_addr = 16'h0002;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (b3.if_ack) begin
        n_ack++;
        if (ack_at < 0) begin ack_at = k; rd = b3.if_rdata; end
        b3.if_req = 1'b0;
      end
    end
    b3.if_req = 1'b0;
    n_cmp++;
    if (ack_at != 5 || n_ack != 1) begin
      n_err++; $display("FAIL load_latency: got ack at %0d (count %0d) expected at 5 (count 1)", ack_at, n_ack);
    end
    n_cmp++;
    if (rd !== 16'h1234 || own3 !== 1'b0 || busy3 !== 1'b0) begin
      n_err++; $display("FAIL load_data: got %h owner=%b busy=%b expected 1234 0 0", rd, own3, busy3);
    end
  endtask

  task automatic test_contention();
    logic [5:0] order;
    int ng, c;
    order = '0; ng = 0;
    @(negedge clk);
    b2.if_req = 1'b1; b2.if_addr = 16'h0030;
    b2.d_req = 1'b1; b2.d_we = 1'b1; b2.d_addr = 16'h0050; b2.d_wdata = 16'h1111;
    for (c = 0; c < 80 && ng < 6; c++) begin
      @(negedge clk);
      if (b2.mem_en) begin order = {order[4:0], own2}; ng++; end
      if (b2.if_ack) b2.if_req = 1'b0;
    end
    n_cmp++;
    if (ng != 6 || order !== 6'b111101) begin
      n_err++; $display("FAIL contention_order: got %0d grants %b expected 6 grants 111101", ng, order);
    end
    for (c = 0; c < 20 && !b2.d_ack; c++) @(negedge clk);
    b2.d_req = 1'b0; b2.if_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy2 !== 1'b0) begin
      n_err++; $display("FAIL contention_drain: got busy=%b expected 0", busy2);
    end
  endtask

  task automatic test_hold();
    int c, stray;
    stray = 0;
    @(negedge clk);
    b2.d_req = 1'b1; b2.d_we = 1'b0; b2.d_addr = 16'h0010;
    for (c = 0; c < 12 && !b2.d_ack; c++) @(negedge clk);
    b2.d_req = 1'b0;
    n_cmp++;
    if (b2.d_ack !== 1'b1 || b2.d_rdata !== 16'hA5B5) begin
      n_err++; $display("FAIL hold_dload: got ack=%b rdata=%h expected 1 a5b5", b2.d_ack, b2.d_rdata);
    end
    @(negedge clk);
    b2.if_req = 1'b1; b2.if_addr = 16'h0020;
    for (c = 0; c < 12 && !b2.if_ack; c++) begin
      @(negedge clk);
      if (b2.d_ack) stray++;
    end
    b2.if_req = 1'b0;
    n_cmp++;
    if (b2.if_ack !== 1'b1 || b2.if_rdata !== 16'hA585 || stray != 0) begin
      n_err++;
      $display("FAIL hold_fetch: got ack=%b rdata=%h stray_d_ack=%0d expected 1 a585 0",
               b2.if_ack, b2.if_rdata, stray);
    end
    n_cmp++;
    if (b2.d_rdata !== 16'hA5B5) begin
      n_err++; $display("FAIL hold_drdata: got %h expected a5b5", b2.d_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int nack, last, consec;
    logic prev_en;
    nack = 0; last = 0; consec = 0; prev_en = 1'b0;
    @(negedge clk);
    b1.if_req = 1'b1; b1.if_addr = 16'h0100;
    for (int cyc = 1; cyc <= 60 && nack < 8; cyc++) begin
      @(negedge clk);
      if (b1.mem_en && prev_en) consec++;
      prev_en = b1.mem_en;
      if (b1.if_ack) begin
        n_cmp++;
        if (cyc - last != ((nack == 0) ? 3 : 4)) begin
          n_err++; $display("FAIL b2b_gap%0d: got %0d cycles expected %0d", nack, cyc - last, (nack == 0) ? 3 : 4);
        end
        n_cmp++;
        if (b1.if_rdata !== mem_fn(b1.if_addr)) begin
          n_err++; $display("FAIL b2b_data%0d: got %h expected %h", nack, b1.if_rdata, mem_fn(b1.if_addr));
        end
        last = cyc;
        nack++;
        if (nack < 8) b1.if_addr = 16'h0100 + 16'(nack * 2);
        else b1.if_req = 1'b0;
      end
    end
    b1.if_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (nack != 8 || consec != 0 || busy1 !== 1'b0 || own1 !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_total: got acks=%0d consec_en=%0d busy=%b owner=%b expected 8 0 0 0",
               nack, consec, busy1, own1);
    end
  endtask

  initial begin
    rst = 1'b1;
    b1.if_req = 1'b0; b1.if_addr = '0; b1.d_req = 1'b0; b1.d_we = 1'b0; b1.d_addr = '0; b1.d_wdata = '0;
    b2.if_req = 1'b0; b2.if_addr = '0; b2.d_req = 1'b0; b2.d_we = 1'b0; b2.d_addr = '0; b2.d_wdata = '0;
    b3.if_req = 1'b0; b3.if_addr = '0; b3.d_req = 1'b0; b3.d_we = 1'b0; b3.d_addr = '0; b3.d_wdata = '0;
    test_reset();
    test_store();
    test_load();
    test_contention();
    test_hold();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbiter that shares one single-ported unified memory between the CPU instruction-fetch port and its data (LW/SW) port. Each port uses a level-held request with a one-cycle acknowledge. The arbiter sequences each access through a fixed-latency memory interface and returns read data to the winning port. It sits between the CPU core and the memory, replacing the split instruction and data memories once the core is stall-capable.

## Interface
Parameters:
- AW, 16, address width, byte address passed through unchanged
- DW, 16, data width
- LAT, 2, memory read latency in cycles (legal 1..7)
- MAX_DATA_BURST, 4, consecutive data grants allowed while fetch waits (legal 1..15)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- if_req  in  1  fetch request; held until if_ack
- if_addr  in  AW  fetch address; stable while if_req
- if_rdata  out  DW  fetch data; valid when if_ack
- if_ack  out  1  one-cycle completion pulse
- d_req  in  1  data request; held until d_ack
- d_we  in  1  1 = store, 0 = load; stable while d_req
- d_addr  in  AW  data address; stable while d_req
- d_wdata  in  DW  store data; stable while d_req
- d_rdata  out  DW  load data; valid when d_ack
- d_ack  out  1  one-cycle completion pulse (loads and stores)
- mem_en  out  1  memory access strobe; exactly one cycle per transaction
- mem_we  out  1  write enable; qualified by mem_en
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  read data; valid exactly LAT cycles after the mem_en cycle
- busy  out  1  high in any state other than IDLE
- owner  out  1  current or last owner: 0 = fetch, 1 = data

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT and RESP.
- **IDLE:** if any request is high, choose a winner and latch its address, we and wdata into the mem_* registers, then go to ISSUE. Fetch is always a read.
- **ISSUE:** mem_en=1. A write goes to RESP. A read loads the latency counter with LAT and goes to WAIT.
- **WAIT:** the counter decrements each cycle. In the cycle where the counter reaches 1, mem_rdata is captured into the owner's rdata register and the FSM goes to RESP.
- **RESP:** the owner's ack is 1, then the FSM returns to IDLE. The non-owner's ack stays 0.
- **Priority:** data beats fetch by default. The starvation counter increments on each data grant made while if_req=1, and clears on any fetch grant. When the counter equals MAX_DATA_BURST and if_req=1, fetch wins once.
- if_rdata and d_rdata hold their value until the next read completes for that port.
- A request that drops before its grant is simply not seen. Dropping a request after grant is illegal; the transaction still completes and acks.
- **Reset:** clears all registers in any state and abandons any in-flight transaction with no ack. Post-reset values: state=IDLE, all outputs 0, starvation counter 0.

## Timing
- A request sampled high in IDLE cycle t produces mem_en in cycle t+1.
- Store: ack in t+2.
- Load: mem_rdata sampled at the end of cycle t+1+LAT; ack and rdata valid in t+2+LAT.
- The earliest next grant is sampled in the IDLE cycle immediately after RESP. Peak load throughput is one transaction per LAT+3 cycles.
- All outputs are registered; there is no combinational path from input to output.
- Simultaneous if_req and d_req in IDLE: data wins unless the starvation rule applies.

## Structure
- The shared package cpu_pkg holds:
  - the state encoding (IDLE, ISSUE, WAIT, RESP)
  - the owner encodings OWN_IF=1'b0 and OWN_D=1'b1
  - the default LAT and MAX_DATA_BURST constants
- One sub-module, arb_prio: the starvation counter plus winner selection. Inputs are if_req, d_req and the grant event; the output is the winner.
- The FSM, latency counter and datapath registers stay in mem_arbiter.

## Test plan
- **Reset:** assert rst mid-WAIT with LAT=2 -> all outputs 0 immediately, no ack; after release, busy=0.
- **Store:** d_req, d_we=1, d_addr=16'h0040, d_wdata=16'hBEEF -> mem_en/mem_we=1 with mem_addr=16'h0040 one cycle after the grant; d_ack two cycles after the grant.
- **Load, LAT=3:** if_req, if_addr=16'h0002, model returns 16'h1234 -> if_ack with if_rdata=16'h1234 exactly 5 cycles after the request was sampled.
- **Contention:** if_req and d_req both high, MAX_DATA_BURST=4, data requester re-requests continuously -> grant order D, D, D, D, IF, D…
- **Hold:** a d_req load completes; next a fetch completes -> d_rdata is unchanged by the fetch.
- **Back-to-back:** 8 fetch loads with LAT=1 -> one if_ack every 4 cycles, mem_en never high for two consecutive cycles.
